// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// Walks the enabled digits, inserting an all-dark gap before each one to avoid ghosting.
module seg_scan_ctrl #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] digit_en,
    input  logic [3:0] dp_in,
    output logic [1:0] sel,
    output logic [3:0] anode,
    output logic       dp,
    output logic       frame_done,
    output logic [1:0] dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    // Where a digit goes after its dwell: into the gap, or straight to the next digit.
    localparam state_t GAP_STATE = (BLANK_CYCLES > 0) ? S_BLANK : S_SHOW;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       anode_q, anode_d;
    logic             dp_q, dp_d;
    logic             frame_q, frame_d;

    logic             run;
    logic             show_exit;
    logic [1:0]       nxt;

    function automatic logic [1:0] next_idx(input logic [1:0] s, input logic [3:0] en);
        logic [1:0] res;
        logic [1:0] idx;
        logic       found;
        res   = s;
        found = 1'b0;
        for (int k = 1; k < 4; k++) begin
            idx = s + 2'(k);
            if (!found && en[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [1:0] first_idx(input logic [3:0] en);
        logic [1:0] res;
        res = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (en[i]) res = 2'(i);
        end
        return res;
    endfunction

    assign run       = enable && (digit_en != 4'd0);
    assign show_exit = !digit_en[sel_q] || (cnt_q == DWELL_LAST);
    assign nxt       = next_idx(sel_q, digit_en);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            anode_q <= 4'b1111;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            anode_q <= anode_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!run) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = GAP_STATE;
                S_BLANK: if (cnt_q == BLANK_LAST) state_d = S_SHOW;
                S_SHOW:  if (show_exit) state_d = GAP_STATE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up with the state they belong to.
    always_comb begin
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        frame_d = 1'b0;
        if (!run) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sel_d = first_idx(digit_en);
                    cnt_d = '0;
                end
                S_BLANK: cnt_d = (cnt_q == BLANK_LAST) ? '0 : cnt_q + CNT_W'(1);
                S_SHOW: begin
                    if (show_exit) begin
                        sel_d   = nxt;
                        cnt_d   = '0;
                        frame_d = (nxt <= sel_q);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: cnt_d = '0;
            endcase
        end
        anode_d = (state_d == S_SHOW) ? ~(4'b0001 << sel_d) : 4'b1111;
        dp_d    = (state_d == S_SHOW) ? ~dp_in[sel_d] : 1'b1;
    end

    assign sel         = sel_q;
    assign anode       = anode_q;
    assign dp          = dp_q;
    assign frame_done  = frame_q;
    assign dbg_state_o = state_q;
endmodule
